// File: rtl/alu_shift_arbiter.sv
// Round-robin arbiter sharing one combinational 32-bit shift unit
// (SLL/SAR/ROL/ROR) between NUM_REQ requesters. The result is captured in a
// one-entry output register and returned with the requester ID.
module alu_shift_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ*32-1:0] req_a,
   input  logic [NUM_REQ*32-1:0] req_b,
   input  logic [NUM_REQ*4-1:0]  req_op,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [31:0]           resp_result,
   output logic [ID_W-1:0]       resp_id,
   output logic                  resp_err
);

   localparam logic [3:0]      OP_SLL   = 4'b0101;
   localparam logic [3:0]      OP_SAR   = 4'b0110;
   localparam logic [3:0]      OP_ROL   = 4'b0111;
   localparam logic [3:0]      OP_ROR   = 4'b1000;
   localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ - 1);

   logic [31:0]     a_arr  [NUM_REQ];
   logic [31:0]     b_arr  [NUM_REQ];
   logic [3:0]      op_arr [NUM_REQ];

   logic [ID_W-1:0] last_grant_q, last_grant_d;
   logic            resp_valid_q, resp_valid_d;
   logic [31:0]     resp_result_q, resp_result_d;
   logic [ID_W-1:0] resp_id_q, resp_id_d;
   logic            resp_err_q, resp_err_d;

   logic            slot_free;
   logic            grant_found;
   logic [ID_W-1:0] grant_idx;
   logic [ID_W-1:0] cand;
   logic            xfer;
   logic [31:0]     sh_a, sh_b, sh_result;
   logic [3:0]      sh_op;
   logic            sh_err;

   // Unpack the flat request buses into per-requester views
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi]  = req_a[32*gi +: 32];
      assign b_arr[gi]  = req_b[32*gi +: 32];
      assign op_arr[gi] = req_op[4*gi +: 4];
   end

   assign slot_free = !resp_valid_q || resp_ready;

   // Round-robin search starting just after the last granted requester
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = last_grant_q;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // One-hot accept, suppressed while the output slot is busy or in reset
   always_comb begin
      req_ready = '0;
      if (rst_n && slot_free && grant_found) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   assign xfer = |(req_valid & req_ready);
   assign sh_a  = a_arr[grant_idx];
   assign sh_b  = b_arr[grant_idx];
   assign sh_op = op_arr[grant_idx];

   // Shared shifter: logical shifts saturate on wide B, rotates use B[4:0]
   always_comb begin
      sh_result = '0;
      sh_err    = 1'b0;
      if (xfer) begin
         case (sh_op)
            OP_SLL: sh_result = (sh_b > 32'd31) ? 32'd0 : (sh_a << sh_b[4:0]);
            OP_SAR: sh_result = (sh_b > 32'd31) ? {32{sh_a[31]}}
                                                : 32'($signed(sh_a) >>> sh_b[4:0]);
            OP_ROL: sh_result = (sh_a << sh_b[4:0]) | (sh_a >> (6'd32 - {1'b0, sh_b[4:0]}));
            OP_ROR: sh_result = (sh_a >> sh_b[4:0]) | (sh_a << (6'd32 - {1'b0, sh_b[4:0]}));
            default: begin
               sh_result = '0;
               sh_err    = 1'b1;
            end
         endcase
      end
   end

   // Output slot and pointer next-state: load on transfer, clear on drain
   always_comb begin
      last_grant_d  = last_grant_q;
      resp_valid_d  = resp_valid_q;
      resp_result_d = resp_result_q;
      resp_id_d     = resp_id_q;
      resp_err_d    = resp_err_q;
      if (xfer) begin
         last_grant_d  = grant_idx;
         resp_valid_d  = 1'b1;
         resp_result_d = sh_result;
         resp_id_d     = grant_idx;
         resp_err_d    = sh_err;
      end else if (resp_ready) begin
         resp_valid_d = 1'b0;
      end
   end

   // State registers; reset points the arbiter so requester 0 goes first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q  <= LAST_IDX;
         resp_valid_q  <= 1'b0;
         resp_result_q <= '0;
         resp_id_q     <= '0;
         resp_err_q    <= 1'b0;
      end else begin
         last_grant_q  <= last_grant_d;
         resp_valid_q  <= resp_valid_d;
         resp_result_q <= resp_result_d;
         resp_id_q     <= resp_id_d;
         resp_err_q    <= resp_err_d;
      end
   end

   assign resp_valid  = resp_valid_q;
   assign resp_result = resp_result_q;
   assign resp_id     = resp_id_q;
   assign resp_err    = resp_err_q;

endmodule

// File: tb/tb_alu_shift_arbiter.sv
// Self-checking bench for alu_shift_arbiter: directed scenarios followed by
// randomized traffic, all checked against a behavioural model.
module tb_alu_shift_arbiter;
   localparam int N  = 4;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*32-1:0] req_a;
   logic [N*32-1:0] req_b;
   logic [N*4-1:0]  req_op;
   logic            resp_valid;
   logic            resp_ready;
   logic [31:0]     resp_result;
   logic [IW-1:0]   resp_id;
   logic            resp_err;

   always #5 clk = ~clk;

   alu_shift_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_result(resp_result), .resp_id(resp_id), .resp_err(resp_err)
   );

   int errors = 0;
   int checks = 0;

   // Requester-side state held by the bench
   logic [31:0] cur_a  [N];
   logic [31:0] cur_b  [N];
   logic [3:0]  cur_op [N];
   bit          cur_v  [N];

   // Behavioural model state
   int          m_ptr;
   bit          m_valid;
   logic [31:0] m_res;
   int          m_id;
   bit          m_err;
   bit          last_xfer;
   int          last_g;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference shifter built from single-bit steps
   function automatic logic [32:0] ref_shift(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] op);
      logic [31:0] r;
      int unsigned n;
      r = a;
      n = (b > 32'd33) ? 33 : b;
      case (op)
         4'd5: begin
            for (int unsigned i = 0; i < n; i++) r = {r[30:0], 1'b0};
            return {1'b0, r};
         end
         4'd6: begin
            for (int unsigned i = 0; i < n; i++) r = {r[31], r[31:1]};
            return {1'b0, r};
         end
         4'd7: begin
            for (int unsigned i = 0; i < (b % 32); i++) r = {r[30:0], r[31]};
            return {1'b0, r};
         end
         4'd8: begin
            for (int unsigned i = 0; i < (b % 32); i++) r = {r[0], r[31:1]};
            return {1'b0, r};
         end
         default: return {1'b1, 32'd0};
      endcase
   endfunction

   function automatic logic [3:0] rand_op();
      int p;
      p = $urandom_range(0, 4);
      if (p < 4) return 4'(5 + p);
      return 4'($urandom);
   endfunction

   function automatic logic [31:0] rand_b();
      if ($urandom_range(0, 3) == 0) return $urandom;
      return $urandom_range(0, 40);
   endfunction

   task automatic new_req(input int i);
      cur_v[i]  = 1'b1;
      cur_a[i]  = $urandom;
      cur_b[i]  = rand_b();
      cur_op[i] = rand_op();
   endtask

   task automatic model_reset();
      m_ptr   = N - 1;
      m_valid = 1'b0;
      m_res   = '0;
      m_id    = 0;
      m_err   = 1'b0;
   endtask

   // One clock: drive, check accept, clock, check the registered result.
   // Called at posedge+1 and returns at the next posedge+1.
   task automatic step();
      logic [N-1:0] exp_ready;
      logic [32:0]  r;
      int           g;
      int           c;
      bit           found;
      bit           slot;
      for (int i = 0; i < N; i++) begin
         req_valid[i]      = cur_v[i];
         req_a[32*i +: 32] = cur_a[i];
         req_b[32*i +: 32] = cur_b[i];
         req_op[4*i +: 4]  = cur_op[i];
      end
      #1;
      slot  = !m_valid || resp_ready;
      found = 1'b0;
      g     = 0;
      for (int k = 1; k <= N; k++) begin
         c = (m_ptr + k) % N;
         if (!found && cur_v[c]) begin
            found = 1'b1;
            g     = c;
         end
      end
      exp_ready = '0;
      if (slot && found) exp_ready[g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      @(posedge clk);
      last_xfer = slot && found;
      last_g    = g;
      if (last_xfer) begin
         r       = ref_shift(cur_a[g], cur_b[g], cur_op[g]);
         m_err   = r[32];
         m_res   = r[31:0];
         m_id    = g;
         m_valid = 1'b1;
         m_ptr   = g;
      end else if (resp_ready) begin
         m_valid = 1'b0;
      end
      #1;
      $display("cycle t=%0t xfer=%0d grant=%0d resp_valid=%0d id=%0d result=%h err=%0d",
               $time, last_xfer, g, resp_valid, resp_id, resp_result, resp_err);
      chk("resp_valid", 32'(resp_valid), 32'(m_valid));
      if (m_valid) begin
         chk("resp_result", resp_result, m_res);
         chk("resp_id", 32'(resp_id), 32'(m_id));
         chk("resp_err", 32'(resp_err), 32'(m_err));
      end
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < N; i++) begin
         cur_v[i]  = 1'b0;
         cur_a[i]  = '0;
         cur_b[i]  = '0;
         cur_op[i] = '0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_valid", 32'(resp_valid), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("rst_result", resp_result, 32'd0);
      chk("rst_id", 32'(resp_id), 32'd0);
      chk("rst_err", 32'(resp_err), 32'd0);
      model_reset();
      rst_n = 1'b1;
   endtask

   task automatic single(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [31:0] exp_res,
                         input logic exp_err, input string tag);
      clear_reqs();
      cur_v[id]  = 1'b1;
      cur_a[id]  = a;
      cur_b[id]  = b;
      cur_op[id] = op;
      resp_ready = 1'b1;
      step();
      chk(tag, resp_result, exp_res);
      chk({tag, "_id"}, 32'(resp_id), 32'(id));
      chk({tag, "_err"}, 32'(resp_err), 32'(exp_err));
      cur_v[id] = 1'b0;
   endtask

   int          seq_skip [6] = '{0, 2, 3, 0, 2, 3};
   logic [31:0] hold_res;
   int          hold_id;

   initial begin
      clear_reqs();
      model_reset();
      resp_ready = 1'b1;
      req_valid  = '1;
      req_a      = '0;
      req_b      = '0;
      req_op     = '0;
      rst_n      = 1'b0;
      // Accepts must stay low while reset is held, even with requests pending
      #1;
      chk("rst_hold_ready", 32'(req_ready), 32'd0);
      do_reset();

      // Single request and operation boundaries
      single(0, 32'h0000_00F0, 32'd4,  4'b0101, 32'h0000_0F00, 1'b0, "sll4");
      single(1, 32'h8000_0000, 32'd31, 4'b0110, 32'hFFFF_FFFF, 1'b0, "sar31");
      single(1, 32'h8000_0000, 32'd40, 4'b0110, 32'hFFFF_FFFF, 1'b0, "sar40");
      single(1, 32'hDEAD_BEEF, 32'd32, 4'b0101, 32'h0000_0000, 1'b0, "sll32");
      single(1, 32'h8000_0001, 32'd1,  4'b0111, 32'h0000_0003, 1'b0, "rol1");
      single(1, 32'h0000_0001, 32'd33, 4'b1000, 32'h8000_0000, 1'b0, "ror33");
      single(1, 32'h1357_9BDF, 32'd0,  4'b0111, 32'h1357_9BDF, 1'b0, "rol0");

      // Round robin with all requesters busy
      do_reset();
      for (int i = 0; i < N; i++) new_req(i);
      resp_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         chk("rr_seq", 32'(resp_id), 32'(k % N));
         if (last_xfer) new_req(last_g);
      end
      for (int k = 0; k < 6; k++) begin
         cur_v[1] = 1'b0;
         step();
         chk("rr_skip", 32'(resp_id), 32'(seq_skip[k]));
         if (last_xfer) new_req(last_g);
      end

      // Backpressure: result held, no accepts, then drain with no bubble
      new_req(1);
      step();
      if (last_xfer) new_req(last_g);
      hold_res   = m_res;
      hold_id    = m_id;
      resp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("bp_ready", 32'(req_ready), 32'd0);
         chk("bp_hold_res", resp_result, hold_res);
         chk("bp_hold_id", 32'(resp_id), 32'(hold_id));
      end
      resp_ready = 1'b1;
      step();
      chk("bp_nobubble", 32'(resp_valid), 32'd1);
      chk("bp_next_id", 32'(resp_id), 32'((hold_id + 1) % N));

      // Illegal opcode; pointer still advances past requester 2
      single(2, 32'h1234_5678, 32'd3, 4'b0000, 32'd0, 1'b1, "illegal");
      for (int i = 0; i < N; i++) new_req(i);
      step();
      chk("illegal_ptr", 32'(resp_id), 32'd3);

      // Reset while a result is stalled
      resp_ready = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(resp_valid), 32'd0);
      chk("midrst_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      model_reset();
      rst_n      = 1'b1;
      resp_ready = 1'b1;
      for (int i = 0; i < N; i++) new_req(i);
      step();
      chk("midrst_first", 32'(resp_id), 32'd0);
      if (last_xfer) new_req(last_g);

      // Randomized traffic against the model
      for (int cyc = 0; cyc < 400; cyc++) begin
         resp_ready = ($urandom_range(0, 3) != 0);
         step();
         if (last_xfer) cur_v[last_g] = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (!cur_v[i] && $urandom_range(0, 99) < 60) new_req(i);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
